// File: rtl/scariv_refill_responder.sv
// Refill responder: forwards miss requests to memory, pairs in-order memory data
// with the requesting miss-entry tag, and buffers responses back to the miss unit.
module scariv_refill_responder #(
    parameter int DATA_W  = 128,
    parameter int DEPTH   = 2,
    parameter int TAG_W   = 1,
    parameter int PADDR_W = 56
) (
    input  logic                         i_clk,
    input  logic                         i_reset,

    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic [TAG_W-1:0]             i_req_tag,
    input  logic [PADDR_W-1:0]           i_req_paddr,

    output logic                         o_mem_req_valid,
    input  logic                         i_mem_req_ready,
    output logic [PADDR_W-1:0]           o_mem_req_paddr,

    input  logic                         i_mem_resp_valid,
    input  logic [DATA_W-1:0]            i_mem_resp_data,

    output logic                         o_resp_valid,
    input  logic                         i_resp_ready,
    output logic [TAG_W-1:0]             o_resp_tag,
    output logic [DATA_W-1:0]            o_resp_data,

    output logic [$clog2(DEPTH+1)-1:0]   o_outstanding,
    output logic                         o_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  tag_cnt;
    logic [CNT_W-1:0]  rb_cnt;
    logic [PTR_W-1:0]  tag_wptr;
    logic [PTR_W-1:0]  tag_rptr;
    logic [PTR_W-1:0]  rb_wptr;
    logic [PTR_W-1:0]  rb_rptr;
    logic [TAG_W-1:0]  tag_mem [DEPTH];
    logic [TAG_W-1:0]  rb_tag  [DEPTH];
    logic [DATA_W-1:0] rb_data [DEPTH];
    logic              err;

    logic not_full;
    logic req_fire;
    logic resp_fire;
    logic mem_fire;
    logic spurious;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Admission is gated by the registered count, so a pop in the same cycle
    // cannot reopen the request path until the following cycle.
    always_comb begin
        not_full        = (count < CNT_W'(DEPTH));
        o_req_ready     = !i_reset && i_mem_req_ready && not_full;
        o_mem_req_valid = !i_reset && i_req_valid && not_full;
        o_mem_req_paddr = i_req_paddr;
        o_resp_valid    = !i_reset && (rb_cnt != '0);
        o_resp_tag      = rb_tag[rb_rptr];
        o_resp_data     = rb_data[rb_rptr];
        o_outstanding   = count;
        o_err           = err;

        req_fire  = i_req_valid && o_req_ready;
        resp_fire = o_resp_valid && i_resp_ready;
        mem_fire  = !i_reset && i_mem_resp_valid && (tag_cnt != '0);
        spurious  = !i_reset && i_mem_resp_valid && (tag_cnt == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count    <= '0;
            tag_cnt  <= '0;
            rb_cnt   <= '0;
            tag_wptr <= '0;
            tag_rptr <= '0;
            rb_wptr  <= '0;
            rb_rptr  <= '0;
            err      <= 1'b0;
        end else begin
            case ({req_fire, resp_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            case ({req_fire, mem_fire})
                2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
                2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
                default: tag_cnt <= tag_cnt;
            endcase

            case ({mem_fire, resp_fire})
                2'b10:   rb_cnt <= rb_cnt + CNT_W'(1);
                2'b01:   rb_cnt <= rb_cnt - CNT_W'(1);
                default: rb_cnt <= rb_cnt;
            endcase

            if (req_fire)  tag_wptr <= ptr_inc(tag_wptr);
            if (mem_fire)  tag_rptr <= ptr_inc(tag_rptr);
            if (mem_fire)  rb_wptr  <= ptr_inc(rb_wptr);
            if (resp_fire) rb_rptr  <= ptr_inc(rb_rptr);
            if (spurious)  err      <= 1'b1;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the counters above.
    always_ff @(posedge i_clk) begin
        if (req_fire) begin
            tag_mem[tag_wptr] <= i_req_tag;
        end
        if (mem_fire) begin
            rb_tag[rb_wptr]  <= tag_mem[tag_rptr];
            rb_data[rb_wptr] <= i_mem_resp_data;
        end
    end

endmodule
